// File: rtl/des_key_sequencer.sv
// DES key-schedule sequencer: walks the post-PC1 {C,D} register through the
// 16 rounds (forward for encrypt, reverse for decrypt) and presents each
// {Cn,Dn} value to an external PC2 with a valid/ack handshake.
// Build option: define DES_KEY_ZEROIZE_EN to clear the CD register whenever
// no round value is being presented (IDLE, DONE, after abort).
//
// state | meaning
// IDLE  | ready for start; no round value presented
// RUN   | presenting round value, advancing on cd_ack
// DONE  | one-cycle done pulse after the last round is acked
module des_key_sequencer #(
  parameter logic [15:0] SHIFT_MAP = 16'h8103
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [55:0] pc1_key,
  output logic        ready,
  output logic [55:0] cd_out,
  output logic        cd_valid,
  input  logic        cd_ack,
  output logic [3:0]  key_num,
  output logic [3:0]  round,
  input  logic        abort,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  round_q, round_d;
  logic        dec_q, dec_d;

  logic        first_by2;
  logic        fwd_by2;
  logic        rev_by2;

  // Each 28-bit half rotates on its own; bits never cross between C and D.
  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic by2);
    return by2 ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic by2);
    return by2 ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // Rotation amount per round: a clear SHIFT_MAP bit means rotate by two.
  always_comb begin
    first_by2 = ~SHIFT_MAP[0];
    fwd_by2   = ~SHIFT_MAP[round_q + 4'd1];
    rev_by2   = ~SHIFT_MAP[4'd15 - round_q];
  end

  // State register; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort takes priority over the final ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cd_ack && (round_q == 4'd15)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; key_num only carries meaning while valid.
  always_comb begin
    ready    = (state_q == IDLE);
    cd_valid = (state_q == RUN);
    done     = (state_q == DONE);
    round    = round_q;
    key_num  = 4'd0;
    if (state_q == RUN) begin
      key_num = dec_q ? (4'd15 - round_q) : round_q;
    end
    cd_out = cd_q;
  end

  // Datapath next values: CD register, round position and direction latch.
  always_comb begin
    cd_d    = cd_q;
    round_d = round_q;
    dec_d   = dec_q;
    case (state_q)
      IDLE: begin
        round_d = 4'd0;
`ifdef DES_KEY_ZEROIZE_EN
        cd_d = 56'd0;
`endif
        if (start) begin
          dec_d = decrypt;
          // Decrypt starts at C16/D16, which equals C0/D0 after a full turn.
          cd_d  = decrypt ? pc1_key
                          : {rotl28(pc1_key[55:28], first_by2),
                             rotl28(pc1_key[27:0], first_by2)};
        end
      end
      RUN: begin
        if (abort) begin
          round_d = 4'd0;
`ifdef DES_KEY_ZEROIZE_EN
          cd_d = 56'd0;
`endif
        end else if (cd_ack) begin
          if (round_q == 4'd15) begin
            round_d = 4'd0;
`ifdef DES_KEY_ZEROIZE_EN
            cd_d = 56'd0;
`endif
          end else begin
            round_d = round_q + 4'd1;
            cd_d    = dec_q ? {rotr28(cd_q[55:28], rev_by2), rotr28(cd_q[27:0], rev_by2)}
                            : {rotl28(cd_q[55:28], fwd_by2), rotl28(cd_q[27:0], fwd_by2)};
          end
        end
      end
      DONE: begin
        round_d = 4'd0;
`ifdef DES_KEY_ZEROIZE_EN
        cd_d = 56'd0;
`endif
      end
      default: round_d = 4'd0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cd_q    <= 56'd0;
      round_q <= 4'd0;
      dec_q   <= 1'b0;
    end else begin
      cd_q    <= cd_d;
      round_q <= round_d;
      dec_q   <= dec_d;
    end
  end

endmodule

// File: tb/tb_des_key_sequencer.sv
// Scoreboard bench for des_key_sequencer: stimulus pushes the expected round
// values, a negedge monitor checks every presented value and done pulse.
module tb_des_key_sequencer;

  localparam logic [55:0] KEY = 56'hF0CCAAF556678F;

  // {Cn,Dn} for n = 1..16 of the classic example key, indexed by key_num.
  localparam logic [55:0] TBL [16] = '{
    56'hE19955FAACCF1E, 56'hC332ABF5599E3D, 56'h0CCAAFF56678F5, 56'h332ABFC599E3D5,
    56'hCCAAFF06678F55, 56'h32ABFC399E3D55, 56'hCAAFF0C678F556, 56'h2ABFC339E3D559,
    56'h557F8663C7AAB3, 56'h55FE199F1EAACC, 56'h57F8665C7AAB33, 56'h5FE19951EAACCF,
    56'h7F866557AAB33C, 56'hFE19955EAACCF1, 56'hF866557AAB33C7, 56'hF0CCAAF556678F
  };

  typedef struct packed {
    logic [55:0] cd;
    logic [3:0]  kn;
    logic [3:0]  rnd;
  } item_t;

  logic        clk = 1'b0;
  logic        rst, start, decrypt, cd_ack, abort;
  logic [55:0] pc1_key;
  logic        ready, cd_valid, done;
  logic [55:0] cd_out;
  logic [3:0]  key_num, round;

  item_t exp_q[$];
  int    exp_done = 0;
  int    n_cmp = 0;
  int    n_err = 0;

  des_key_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .pc1_key(pc1_key),
    .ready(ready), .cd_out(cd_out), .cd_valid(cd_valid), .cd_ack(cd_ack),
    .key_num(key_num), .round(round), .abort(abort), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push_seq(input bit dec, input int last);
    item_t it;
    for (int r = 0; r <= last; r++) begin
      it.cd  = dec ? TBL[15 - r] : TBL[r];
      it.kn  = dec ? 4'(15 - r) : 4'(r);
      it.rnd = 4'(r);
      exp_q.push_back(it);
    end
  endtask

  task automatic wait_round(input int r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(posedge clk); #1;
      if (cd_valid && (round == 4'(r))) ok = 1'b1;
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(posedge clk); #1;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},    64'(ready),    64'd1);
    check({tag, "_cd_valid"}, 64'(cd_valid), 64'd0);
    check({tag, "_done"},     64'(done),     64'd0);
    check({tag, "_round"},    64'(round),    64'd0);
    check({tag, "_key_num"},  64'(key_num),  64'd0);
    check({tag, "_cd_out"},   64'(cd_out),   64'd0);
  endtask

  // Monitor: compare every presented round value and every done pulse.
  always @(negedge clk) begin
    item_t e;
    if (cd_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got cd_out %h with nothing expected", cd_out);
      end else begin
        e = exp_q[0];
        check("mon_cd_out",  64'(cd_out),  64'(e.cd));
        check("mon_key_num", 64'(key_num), 64'(e.kn));
        check("mon_round",   64'(round),   64'(e.rnd));
        if (cd_ack || abort || rst) void'(exp_q.pop_front());
      end
    end
    if (done) begin
      if (exp_done == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected 0");
      end else begin
        exp_done--;
        check("done_cd_valid", 64'(cd_valid), 64'd0);
        check("done_acks_left", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [55:0] ret;
    rst = 1'b1; start = 1'b1; abort = 1'b1; cd_ack = 1'b1; decrypt = 1'b1; pc1_key = KEY;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; abort = 1'b0; decrypt = 1'b0;
    check_reset_outputs("rst");

    // cd_ack with nothing presented is ignored
    repeat (3) @(posedge clk);
    #1;
    check("idle_ack_valid", 64'(cd_valid), 64'd0);
    check("idle_ack_round", 64'(round),    64'd0);

    // Encrypt, ack held; start stays high through the run and the DONE cycle
    push_seq(1'b0, 15); exp_done++;
    start = 1'b1;
    @(posedge clk); #1;
    check("enc_latency_valid", 64'(cd_valid), 64'd1);
    check("enc_busy_ready",    64'(ready),    64'd0);
    pc1_key = 56'h0123456789ABCD; decrypt = 1'b1;
    wait_done(ok);
    check("enc_done_seen", 64'(ok), 64'd1);
    @(posedge clk); #1;
    check("done_start_ready", 64'(ready),    64'd1);
    check("done_start_valid", 64'(cd_valid), 64'd0);
    check("done_one_cycle",   64'(done),     64'd0);
    start = 1'b0; decrypt = 1'b0; pc1_key = KEY;
    @(posedge clk); #1;

    // Decrypt; abort asserted in IDLE alongside start must not block it
    push_seq(1'b1, 15); exp_done++;
    decrypt = 1'b1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("dec_first_valid", 64'(cd_valid), 64'd1);
    check("dec_first_kn",    64'(key_num),  64'd15);
    wait_done(ok);
    check("dec_done_seen", 64'(ok), 64'd1);
    @(posedge clk); #1;

    // Backpressure: ack low for 5 cycles at round 3
    push_seq(1'b0, 15); exp_done++;
    decrypt = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_round(3, ok);
    check("bp_round3_seen", 64'(ok), 64'd1);
    cd_ack = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("bp_frozen_round", 64'(round),  64'd3);
    check("bp_frozen_cd",    64'(cd_out), 64'(TBL[3]));
    cd_ack = 1'b1;
    wait_done(ok);
    check("bp_done_seen", 64'(ok), 64'd1);
    @(posedge clk); #1;

    // Abort at round 7
    push_seq(1'b0, 7);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_round(7, ok);
    check("ab7_round_seen", 64'(ok), 64'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
`ifdef DES_KEY_ZEROIZE_EN
    ret = 56'd0;
`else
    ret = TBL[7];
`endif
    check("ab7_ready",    64'(ready),    64'd1);
    check("ab7_cd_valid", 64'(cd_valid), 64'd0);
    check("ab7_done",     64'(done),     64'd0);
    check("ab7_cd_out",   64'(cd_out),   64'(ret));
    @(posedge clk); #1;
    check("ab7_no_late_done", 64'(done), 64'd0);

    // Abort together with the round-15 ack (decrypt)
    push_seq(1'b1, 15);
    decrypt = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_round(15, ok);
    check("ab15_round_seen", 64'(ok), 64'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
`ifdef DES_KEY_ZEROIZE_EN
    ret = 56'd0;
`else
    ret = TBL[0];
`endif
    check("ab15_ready",  64'(ready),  64'd1);
    check("ab15_done",   64'(done),   64'd0);
    check("ab15_cd_out", 64'(cd_out), 64'(ret));
    @(posedge clk); #1;
    check("ab15_no_late_done", 64'(done), 64'd0);

    // Reset at round 10, with start asserted during reset
    push_seq(1'b0, 10);
    decrypt = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_round(10, ok);
    check("rst10_round_seen", 64'(ok), 64'd1);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check_reset_outputs("rst10");

    repeat (3) @(posedge clk);
    #1;
    check("end_queue_empty", 64'(exp_q.size()), 64'd0);
    check("end_done_count",  64'(exp_done),     64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
